// File: rtl/console_seq.sv
// Console sequencer: decodes com-link command phases and drives the configure, trigger and
// conversion/send handshakes of one collect board. Define CONSOLE_SEQ_FRAME_CNT_EN for frame_cnt.
module console_seq #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned IDX_NUM = 6,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned TMO_CYC = 65535,
   parameter int unsigned TMO_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        com_state,
   input  logic              fs_read,
   output logic              fd_read,
   output logic              fs_conf,
   input  logic              fd_conf,
   output logic              fs_trgg,
   input  logic              fd_trgg,
   input  logic              tick,
   output logic              fs_conv,
   input  logic [NUM_CH-1:0] fd_conv,
   output logic              fs_send,
   input  logic              fd_send,
   output logic [IDX_W-1:0]  data_idx,
   output logic              err_tmo,
   output logic [7:0]        ovr_cnt,
   output logic [15:0]       frame_cnt
);

   localparam logic [10:0] StMainIdle = 11'b000_0000_0001;
   localparam logic [10:0] StMainWait = 11'b000_0000_0010;
   localparam logic [10:0] StMainDone = 11'b000_0000_0100;
   localparam logic [10:0] StConfWait = 11'b000_0000_1000;
   localparam logic [10:0] StConfWork = 11'b000_0001_0000;
   localparam logic [10:0] StConfDone = 11'b000_0010_0000;
   localparam logic [10:0] StConvIdle = 11'b000_0100_0000;
   localparam logic [10:0] StConvWait = 11'b000_1000_0000;
   localparam logic [10:0] StConvWork = 11'b001_0000_0000;
   localparam logic [10:0] StConvTake = 11'b010_0000_0000;
   localparam logic [10:0] StConvDone = 11'b100_0000_0000;

   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(IDX_NUM - 1);
   localparam bit               TmoEn   = (TMO_CYC != 0);
   localparam logic [TMO_W-1:0] TmoLast = TmoEn ? TMO_W'(TMO_CYC - 1) : '0;

   logic [10:0]      state_q, state_d;
   logic [1:0]       tick_b;
   logic             tick_rise;
   logic [NUM_CH:0]  mask_q, mask_d, done_now;
   logic             all_done;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;
   logic             in_work;
   logic             abort;
   logic             trgg_q, trgg_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic [7:0]       ovr_q, ovr_d;

   assign tick_rise = (tick_b == 2'b01);

   // Latched done bits plus this cycle's inputs, so a take finishing in its entry cycle
   // leaves after one cycle.
   assign done_now = mask_q | {fd_send, fd_conv};
   assign all_done = &done_now;

   assign in_work = (state_q == StConfWork) || (state_q == StConvTake);
   assign tmo_hit = TmoEn && (tmo_q == TmoLast);

   always_comb begin
      abort = 1'b0;
      if (tmo_hit) begin
         if ((state_q == StConfWork) && !fd_conf) abort = 1'b1;
         if ((state_q == StConvTake) && !all_done) abort = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StMainIdle: state_d = StMainWait;
         StMainWait: begin
            if (fs_read) begin
               case (com_state)
                  2'b01:   state_d = StConfWait;
                  2'b10:   state_d = StConvIdle;
                  default: state_d = StMainDone;
               endcase
            end
         end
         StMainDone: if (!fs_read) state_d = StMainWait;
         StConfWait: if (!fs_read) state_d = StConfWork;
         StConfWork: begin
            if (fd_conf)    state_d = StConfDone;
            else if (abort) state_d = StMainWait;
         end
         StConfDone: state_d = StMainWait;
         StConvIdle: state_d = StConvWait;
         StConvWait: if (!fs_read) state_d = StConvWork;
         StConvWork: begin
            if (tick_rise)    state_d = StConvTake;
            else if (fs_read) state_d = StMainWait;
         end
         StConvTake: begin
            if (all_done)   state_d = StConvDone;
            else if (abort) state_d = StMainWait;
         end
         StConvDone: state_d = com_state[1] ? StConvWork : StMainWait;
         default:    state_d = StMainIdle;
      endcase
   end

   always_comb begin
      mask_d = (state_q == StConvTake) ? done_now : '0;

      if (state_d != state_q) tmo_d = '0;
      else if (in_work)       tmo_d = tmo_q + 1'b1;
      else                    tmo_d = '0;

      if (state_q == StConvIdle) trgg_d = 1'b1;
      else if (fd_trgg)          trgg_d = 1'b0;
      else                       trgg_d = trgg_q;

      idx_d = idx_q;
      if ((state_q == StMainIdle) || (state_q == StConvIdle)) begin
         idx_d = '0;
      end else if (state_q == StConvDone) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end

      err_d = err_q;
      if (abort)                      err_d = 1'b1;
      else if (state_q == StConfDone) err_d = 1'b0;

      // A tick landing while a take is still busy is counted and dropped.
      ovr_d = ovr_q;
      if (tick_rise && ((state_q == StConvTake) || (state_q == StConvDone)) && (ovr_q != 8'hff)) begin
         ovr_d = ovr_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StMainIdle;
         tick_b  <= 2'b00;
         mask_q  <= '0;
         tmo_q   <= '0;
         trgg_q  <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         ovr_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         tick_b  <= {tick_b[0], tick};
         mask_q  <= mask_d;
         tmo_q   <= tmo_d;
         trgg_q  <= trgg_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef CONSOLE_SEQ_FRAME_CNT_EN
   logic [15:0] frame_q;

   always_ff @(posedge clk) begin
      if (rst || (state_q == StConvIdle)) begin
         frame_q <= 16'h0000;
      end else if ((state_q == StConvDone) && (idx_q == IdxLast)) begin
         frame_q <= frame_q + 16'd1;
      end
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = 16'h0000;
`endif

   assign fd_read  = (state_q == StConfWait) || (state_q == StConvWait) || (state_q == StMainDone);
   assign fs_conf  = (state_q == StConfWork);
   assign fs_conv  = (state_q == StConvTake);
   assign fs_send  = (state_q == StConvTake);
   assign fs_trgg  = trgg_q;
   assign data_idx = idx_q;
   assign err_tmo  = err_q;
   assign ovr_cnt  = ovr_q;

endmodule

// File: tb/tb_console_seq.sv
// Directed-random bench for console_seq; expectations come from a take/overrun/error model.
module tb_console_seq;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned IDX_NUM = 6;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned TMO_CYC = 20;
   localparam int unsigned TMO_W   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        com_state;
   logic              fs_read;
   logic              fd_read;
   logic              fs_conf;
   logic              fd_conf;
   logic              fs_trgg;
   logic              fd_trgg;
   logic              tick;
   logic              fs_conv;
   logic [NUM_CH-1:0] fd_conv;
   logic              fs_send;
   logic              fd_send;
   logic [IDX_W-1:0]  data_idx;
   logic              err_tmo;
   logic [7:0]        ovr_cnt;
   logic [15:0]       frame_cnt;

   always #5 clk = ~clk;

   console_seq #(
      .NUM_CH  (NUM_CH),
      .IDX_NUM (IDX_NUM),
      .IDX_W   (IDX_W),
      .TMO_CYC (TMO_CYC),
      .TMO_W   (TMO_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .com_state (com_state),
      .fs_read   (fs_read),
      .fd_read   (fd_read),
      .fs_conf   (fs_conf),
      .fd_conf   (fd_conf),
      .fs_trgg   (fs_trgg),
      .fd_trgg   (fd_trgg),
      .tick      (tick),
      .fs_conv   (fs_conv),
      .fd_conv   (fd_conv),
      .fs_send   (fs_send),
      .fd_send   (fd_send),
      .data_idx  (data_idx),
      .err_tmo   (err_tmo),
      .ovr_cnt   (ovr_cnt),
      .frame_cnt (frame_cnt)
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   // Model: completed takes since the last read start, overrun ticks seen, sticky error.
   int   m_takes;
   int   m_ovr;
   logic m_err;

   function automatic logic [31:0] exp_idx();
      return 32'(m_takes % IDX_NUM);
   endfunction

   function automatic logic [31:0] exp_frame();
`ifdef CONSOLE_SEQ_FRAME_CNT_EN
      return 32'((m_takes / IDX_NUM) % 65536);
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_ovr();
      return (m_ovr > 255) ? 32'd255 : 32'(m_ovr);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_idx"},   32'(data_idx),  exp_idx());
      check({tag, "_frame"}, 32'(frame_cnt), exp_frame());
      check({tag, "_ovr"},   32'(ovr_cnt),   exp_ovr());
      check({tag, "_err"},   32'(err_tmo),   32'(m_err));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
   endtask

   task automatic enter_conf();
      com_state = 2'b01;
      fs_read   = 1'b1;
      step(1);
      fs_read = 1'b0;
      step(1);
   endtask

   task automatic enter_conv();
      com_state = 2'b10;
      fs_read   = 1'b1;
      step(2);
      fs_read = 1'b0;
      step(1);
      m_takes = 0;
   endtask

   initial begin
      int off [0:NUM_CH];
      int last;
      int d;

      rst = 1'b1; com_state = 2'b00; fs_read = 1'b0; fd_conf = 1'b0; fd_trgg = 1'b0;
      tick = 1'b0; fd_conv = '0; fd_send = 1'b0;
      m_takes = 0; m_ovr = 0; m_err = 1'b0;
      step(2);
      check("rst_fd_read", 32'(fd_read), 0);
      check("rst_fs_conf", 32'(fs_conf), 0);
      check("rst_fs_trgg", 32'(fs_trgg), 0);
      check("rst_fs_conv", 32'(fs_conv), 0);
      check("rst_fs_send", 32'(fs_send), 0);
      check_model("rst");
      rst = 1'b0;
      step(2);
      check("idle_fd_read", 32'(fd_read), 0);

      // Configuration handshake
      com_state = 2'b01; fs_read = 1'b1;
      step(1);
      check("confwait_fd_read", 32'(fd_read), 1);
      check("confwait_fs_conf", 32'(fs_conf), 0);
      d = $urandom_range(0, 3);
      repeat (d) begin
         step(1);
         check("confwait_hold", 32'(fd_read), 1);
      end
      fs_read = 1'b0;
      step(1);
      check("confwork_fs_conf", 32'(fs_conf), 1);
      check("confwork_fd_read", 32'(fd_read), 0);
      d = $urandom_range(2, 10);
      repeat (d - 1) begin
         step(1);
         check("confwork_hold", 32'(fs_conf), 1);
      end
      fd_conf = 1'b1;
      step(1);
      fd_conf = 1'b0;
      check("confdone_fs_conf", 32'(fs_conf), 0);
      step(1);
      check("conf_back_fd_read", 32'(fd_read), 0);
      check_model("conf");

      // Configuration timeout
      enter_conf();
      repeat (TMO_CYC - 1) step(1);
      check("conftmo_last_busy", 32'(fs_conf), 1);
      step(1);
      m_err = 1'b1;
      check("conftmo_abort", 32'(fs_conf), 0);
      check_model("conftmo");

      // Done and timeout in the same cycle: done wins, error clears in CONF_DONE
      enter_conf();
      repeat (TMO_CYC - 1) step(1);
      check("confrace_busy", 32'(fs_conf), 1);
      fd_conf = 1'b1;
      step(1);
      fd_conf = 1'b0;
      check("confrace_fs_conf", 32'(fs_conf), 0);
      check("confrace_err_kept", 32'(err_tmo), 1);
      step(1);
      m_err = 1'b0;
      check("confrace_err_clr", 32'(err_tmo), 0);

      // IDLE/SAME command goes through MAIN_DONE
      com_state = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      fs_read = 1'b1;
      d = $urandom_range(1, 3);
      repeat (d) begin
         step(1);
         check("maindone_fd_read", 32'(fd_read), 1);
      end
      fs_read = 1'b0;
      step(1);
      check("maindone_exit", 32'(fd_read), 0);

      // Read stream
      com_state = 2'b10; fs_read = 1'b1;
      step(1);
      check("convidle_fd_read", 32'(fd_read), 0);
      check("convidle_trgg", 32'(fs_trgg), 0);
      step(1);
      m_takes = 0;
      check("convwait_fd_read", 32'(fd_read), 1);
      check("convwait_trgg", 32'(fs_trgg), 1);
      check_model("convwait");
      fs_read = 1'b0;
      step(1);
      check("convwork_fd_read", 32'(fd_read), 0);
      d = $urandom_range(0, 4);
      repeat (d) begin
         step(1);
         check("trgg_hold", 32'(fs_trgg), 1);
      end
      fd_trgg = 1'b1;
      step(1);
      fd_trgg = 1'b0;
      check("trgg_clr", 32'(fs_trgg), 0);

      for (int k = 0; k < 7; k++) begin
         tick_pulse();
         check("take_fs_conv", 32'(fs_conv), 1);
         check("take_fs_send", 32'(fs_send), 1);
         last = 0;
         for (int b = 0; b <= NUM_CH; b++) begin
            off[b] = $urandom_range(0, 3);
            if (k == 2 && b == NUM_CH) off[b] = 3;
            if (off[b] > last) last = off[b];
         end
         for (int c = 0; c <= last; c++) begin
            for (int b = 0; b < NUM_CH; b++) fd_conv[b] = (off[b] == c);
            fd_send = (off[NUM_CH] == c);
            tick    = (k == 2 && c == 0);
            check("take_busy", 32'(fs_conv), 1);
            step(1);
         end
         fd_conv = '0; fd_send = 1'b0; tick = 1'b0;
         if (k == 2) m_ovr++;
         check("convdone_fs_conv", 32'(fs_conv), 0);
         check("convdone_idx_held", 32'(data_idx), exp_idx());
         m_takes++;
         step(1);
         check_model("stream");
         if (k == 2) begin
            step(3);
            check("ovr_no_extra_take", 32'(fs_conv), 0);
         end
      end
      check("stream_trgg_low", 32'(fs_trgg), 0);

      // Partial done: one done bit never arrives
      tick_pulse();
      check("partial_fs_conv", 32'(fs_conv), 1);
      d = $urandom_range(0, NUM_CH);
      fd_conv = '1; fd_send = 1'b1;
      if (d == NUM_CH) fd_send = 1'b0;
      else fd_conv[d] = 1'b0;
      step(1);
      fd_conv = '0; fd_send = 1'b0;
      repeat (TMO_CYC - 2) step(1);
      check("partial_last_busy", 32'(fs_conv), 1);
      step(1);
      m_err = 1'b1;
      check("partial_abort", 32'(fs_conv), 0);
      check("partial_fd_read", 32'(fd_read), 0);
      check_model("partial");
      tick_pulse();
      check("mainwait_tick_ignored", 32'(fs_conv), 0);

      // Tick and fs_read together in CONV_WORK: tick wins
      enter_conv();
      check_model("reenter");
      tick = 1'b1;
      step(1);
      tick = 1'b0; fs_read = 1'b1;
      step(1);
      check("tick_prio", 32'(fs_conv), 1);
      fs_read = 1'b0; fd_conv = '1; fd_send = 1'b1;
      step(1);
      fd_conv = '0; fd_send = 1'b0;
      check("one_cycle_take", 32'(fs_conv), 0);
      com_state = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b01;
      step(1);
      m_takes++;
      check_model("done_to_main");
      tick_pulse();
      check("done_to_main_no_take", 32'(fs_conv), 0);

      // Overrun saturation: 8 overrun ticks per take
      enter_conv();
      for (int t = 0; t < 38; t++) begin
         tick_pulse();
         repeat (8) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
         end
         m_ovr += 8;
         check("sat_take_busy", 32'(fs_conv), 1);
         fd_conv = '1; fd_send = 1'b1;
         step(1);
         fd_conv = '0; fd_send = 1'b0;
         step(1);
         m_takes++;
         check_model("sat");
      end

      // Reset in the middle of a take
      tick_pulse();
      check("prerst_fs_conv", 32'(fs_conv), 1);
      check("prerst_trgg", 32'(fs_trgg), 1);
      check("prerst_err", 32'(err_tmo), 1);
      rst = 1'b1;
      step(1);
      m_takes = 0; m_ovr = 0; m_err = 1'b0;
      check("midrst_fs_conv", 32'(fs_conv), 0);
      check("midrst_fs_send", 32'(fs_send), 0);
      check("midrst_fs_trgg", 32'(fs_trgg), 0);
      check("midrst_fd_read", 32'(fd_read), 0);
      check_model("midrst");
      com_state = 2'b01; fs_read = 1'b1;
      rst = 1'b0;
      step(1);
      check("postrst_idle_step", 32'(fd_read), 0);
      step(1);
      check("postrst_confwait", 32'(fd_read), 1);
      fs_read = 1'b0;
      step(1);
      check("postrst_confwork", 32'(fs_conf), 1);
      fd_conf = 1'b1;
      step(1);
      fd_conf = 1'b0;
      step(1);

      // fs_read in CONV_WORK without a tick leaves to MAIN_WAIT
      enter_conv();
      com_state = 2'b00; fs_read = 1'b1;
      step(1);
      check("convwork_exit", 32'(fd_read), 0);
      step(1);
      check("convwork_exit_maindone", 32'(fd_read), 1);
      fs_read = 1'b0;
      step(1);
      check("final_fd_read", 32'(fd_read), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/console_seq.md
Name: console_seq

Overview:
- Parametrised successor of the console sequencer; one instance per collect board.
- Decodes command phases from the com link (fs_read/fd_read, com_state) and drives configuration, trigger and conversion/send handshakes.
- Steps data_idx over IDX_NUM slots on each sample tick.
- New over the previous generation:
  - N-channel conversion-done aggregation.
  - Handshake timeout with sticky error flag.
  - Tick-overrun counter.
  - Optional frame counter.

Parameters:
- NUM_CH, 4, number of conversion channels whose fd_conv must all complete per take.
- IDX_NUM, 6, number of data_idx slots; data_idx wraps IDX_NUM-1 -> 0. Legal range 1..2^IDX_W.
- IDX_W, 4, width of data_idx.
- TMO_CYC, 65535, cycles allowed in CONF_WORK or CONV_TAKE before abort; 0 disables timeout.
- TMO_W, 16, width of timeout counter; TMO_CYC must fit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- com_state  in  2  command: 00 IDLE, 01 CONF, 10 READ, 11 SAME
- fs_read  in  1  command-valid level from com
- fd_read  out  1  command accepted
- fs_conf  out  1  configure request (level)
- fd_conf  in  1  configure done
- fs_trgg  out  1  trigger request (level, registered)
- fd_trgg  in  1  trigger done
- tick  in  1  sample tick, asynchronous to sequence; level
- fs_conv  out  1  conversion request (level)
- fd_conv  in  NUM_CH  per-channel conversion done (pulse or level)
- fs_send  out  1  send request (level)
- fd_send  in  1  send done (pulse or level)
- data_idx  out  IDX_W  current slot
- err_tmo  out  1  sticky timeout flag
- ovr_cnt  out  8  tick overruns, saturating at 255
- frame_cnt  out  16  completed frames (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State MAIN_IDLE; all outputs 0.
  - Done mask and counters cleared.
  - rst mid-handshake drops every fs_* on the next edge.
- Tick edge: 2-flop history tick_b; tick_rise = (tick_b == 2'b01).
- States (one-hot) and transitions:
  - MAIN_IDLE -> MAIN_WAIT.
  - MAIN_WAIT: fs_read with com_state=01 -> CONF_WAIT; fs_read with 10 -> CONV_IDLE; fs_read with 00/11 -> MAIN_DONE; otherwise stay.
  - MAIN_DONE: stay while fs_read; ~fs_read -> MAIN_WAIT.
  - CONF_WAIT: ~fs_read -> CONF_WORK.
  - CONF_WORK: fd_conf -> CONF_DONE; timeout -> MAIN_WAIT.
  - CONF_DONE -> MAIN_WAIT.
  - CONV_IDLE -> CONV_WAIT.
  - CONV_WAIT: ~fs_read -> CONV_WORK.
  - CONV_WORK: tick_rise -> CONV_TAKE (tick has priority); else fs_read -> MAIN_WAIT; else stay.
  - CONV_TAKE: all done-mask bits set -> CONV_DONE; timeout -> MAIN_WAIT.
  - CONV_DONE: com_state 10/11 -> CONV_WORK; else MAIN_WAIT.
  - Illegal encoding -> MAIN_IDLE.
- Outputs:
  - fd_read = CONF_WAIT | CONV_WAIT | MAIN_DONE.
  - fs_conf = CONF_WORK.
  - fs_conv = fs_send = CONV_TAKE.
- Done mask (NUM_CH+1 bits):
  - Cleared on entry to CONV_TAKE.
  - Bit i set by fd_conv[i]; bit NUM_CH set by fd_send.
  - Bits latch, so pulses arriving on different cycles complete the take.
  - Completion is evaluated on the registered mask plus current inputs, so everything done in the entry cycle exits after 1 cycle.
- fs_trgg:
  - Set to 1 on the cycle after state==CONV_IDLE.
  - Cleared on the cycle after fd_trgg.
  - Set has priority if both occur.
- data_idx:
  - 0 in MAIN_IDLE or CONV_IDLE.
  - In CONV_DONE: +1, wrapping at IDX_NUM-1 -> 0.
  - Otherwise held. IDX_NUM=1 keeps it at 0.
  - A timeout abort does not advance data_idx.
- Timeout:
  - Counter cleared on every state change.
  - Increments in CONF_WORK/CONV_TAKE.
  - At count == TMO_CYC-1 with done not yet met: abort and set err_tmo.
  - Done and timeout in the same cycle: done wins.
  - err_tmo clears only on rst or on CONF_DONE.
- Overrun: tick_rise while in CONV_TAKE or CONV_DONE increments ovr_cnt (saturating 255). That tick is dropped, not queued.

Optional Feature:
- Macro: CONSOLE_SEQ_FRAME_CNT_EN.
- Defined:
  - frame_cnt increments (wrap 65535 -> 0) in CONV_DONE when data_idx == IDX_NUM-1, i.e. one full slot cycle.
  - Cleared on rst and in CONV_IDLE.
- Undefined: frame_cnt tied to 16'h0000 and no counter flops exist.

Test Plan:
- Config path: fs_read=1, com_state=01, release fs_read; fd_conf pulse 5 cycles later -> fs_conf high exactly while in CONF_WORK, fd_read high during CONF_WAIT, return to MAIN_WAIT, err_tmo=0.
- Read stream, IDX_NUM=6, NUM_CH=4: com_state=10, 7 ticks, fd_conv bits pulsed on staggered cycles, fd_send last -> data_idx sequence 1,2,3,4,5,0,1; fs_trgg pulses once then clears on fd_trgg; frame_cnt=1 when the feature is enabled.
- Partial done: fd_conv=4'b0111 with fd_send only, channel 3 never completes, TMO_CYC=20 -> abort to MAIN_WAIT after 20 cycles in CONV_TAKE, err_tmo=1, data_idx unchanged.
- Overrun: tick edge while in CONV_TAKE -> ovr_cnt 0 -> 1, no extra take; drive 300 overruns -> ovr_cnt saturates at 255.
- Simultaneous events: tick_rise and fs_read together in CONV_WORK -> CONV_TAKE. fd_conf and timeout in the same cycle -> CONF_DONE, err_tmo unchanged.
- Reset mid-take: assert rst while fs_conv=1 -> next edge all outputs 0, state MAIN_IDLE, ovr_cnt=0, err_tmo=0.
